// File: rtl/proc_pkg.sv
// Shared definitions for the 16-bit accumulator processor: opcodes, ALU selects
// and the control-unit state encoding.
package proc_pkg;

  localparam int unsigned LARG_OP  = 4;
  localparam int unsigned LARG_SEL = 3;

  localparam logic [LARG_OP-1:0] OP_NOP = 4'h0;
  localparam logic [LARG_OP-1:0] OP_STA = 4'h1;
  localparam logic [LARG_OP-1:0] OP_LDA = 4'h2;
  localparam logic [LARG_OP-1:0] OP_ADD = 4'h3;
  localparam logic [LARG_OP-1:0] OP_SUB = 4'h4;
  localparam logic [LARG_OP-1:0] OP_AND = 4'h5;
  localparam logic [LARG_OP-1:0] OP_OR  = 4'h6;
  localparam logic [LARG_OP-1:0] OP_NOT = 4'h7;
  localparam logic [LARG_OP-1:0] OP_SHR = 4'h8;
  localparam logic [LARG_OP-1:0] OP_SHL = 4'h9;
  localparam logic [LARG_OP-1:0] OP_JMP = 4'hA;
  localparam logic [LARG_OP-1:0] OP_JN  = 4'hB;
  localparam logic [LARG_OP-1:0] OP_JZ  = 4'hC;
  localparam logic [LARG_OP-1:0] OP_HLT = 4'hF;

  localparam logic [LARG_SEL-1:0] ULA_SOMA    = 3'b000;
  localparam logic [LARG_SEL-1:0] ULA_SUB     = 3'b001;
  localparam logic [LARG_SEL-1:0] ULA_AND     = 3'b010;
  localparam logic [LARG_SEL-1:0] ULA_OR      = 3'b011;
  localparam logic [LARG_SEL-1:0] ULA_NOT     = 3'b100;
  localparam logic [LARG_SEL-1:0] ULA_SHR     = 3'b101;
  localparam logic [LARG_SEL-1:0] ULA_SHL     = 3'b110;
  localparam logic [LARG_SEL-1:0] ULA_PASSA_Y = 3'b111;

  typedef enum logic [2:0] {
    RESET,
    BUSCA0,
    BUSCA1,
    BUSCA2,
    DECOD,
    OPER,
    EXEC,
    PARADO
  } estado_t;

endpackage

// File: rtl/decod_ula.sv
// Opcode classifier: ALU select plus instruction class (memory operand, jump, unary).
module decod_ula
  import proc_pkg::*;
(
  input  logic [LARG_OP-1:0]  opcode,
  output logic [LARG_SEL-1:0] sel_ula,
  output logic                e_memoria,
  output logic                e_salto,
  output logic                e_unaria
);

  // Unlisted and unknown opcodes fall through as NOP
  always_comb begin
    sel_ula   = ULA_SOMA;
    e_memoria = 1'b0;
    e_salto   = 1'b0;
    e_unaria  = 1'b0;
    case (opcode)
      OP_STA: e_memoria = 1'b1;
      OP_LDA: begin sel_ula = ULA_PASSA_Y; e_memoria = 1'b1; end
      OP_ADD: begin sel_ula = ULA_SOMA;    e_memoria = 1'b1; end
      OP_SUB: begin sel_ula = ULA_SUB;     e_memoria = 1'b1; end
      OP_AND: begin sel_ula = ULA_AND;     e_memoria = 1'b1; end
      OP_OR:  begin sel_ula = ULA_OR;      e_memoria = 1'b1; end
      OP_NOT: begin sel_ula = ULA_NOT;     e_unaria  = 1'b1; end
      OP_SHR: begin sel_ula = ULA_SHR;     e_unaria  = 1'b1; end
      OP_SHL: begin sel_ula = ULA_SHL;     e_unaria  = 1'b1; end
      OP_JMP, OP_JN, OP_JZ: e_salto = 1'b1;
      OP_NOP, OP_HLT: ;
      default: ;
    endcase
  end

endmodule

// File: rtl/unidade_controle.sv
// Multi-cycle control unit: fetch, decode, operand access and execute against a
// single-port memory with ready handshake and bus-timeout detection.
module unidade_controle
  import proc_pkg::*;
#(
  parameter int unsigned ESPERA_MAX = 255,
  parameter int unsigned LARG_CONT  = 16
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [LARG_OP-1:0]  opcode,
  input  logic                flag_n,
  input  logic                flag_z,
  input  logic                mem_pronto,
  input  logic                continuar,
  output logic [LARG_SEL-1:0] sel_ula,
  output logic                carga_ac,
  output logic                carga_nz,
  output logic                carga_pc,
  output logic                inc_pc,
  output logic                carga_rem,
  output logic                sel_rem,
  output logic                carga_rdm,
  output logic                carga_ri,
  output logic                mem_le,
  output logic                mem_escreve,
  output logic                parado,
  output logic                erro
);

  estado_t              estado, estado_prox;
  logic [LARG_CONT-1:0] cont;
  logic                 set_erro;
  logic                 limite;
  logic [LARG_SEL-1:0]  dec_sel;
  logic                 e_memoria, e_salto, e_unaria;

  decod_ula u_decod (
    .opcode    (opcode),
    .sel_ula   (dec_sel),
    .e_memoria (e_memoria),
    .e_salto   (e_salto),
    .e_unaria  (e_unaria)
  );

  assign limite = (cont == LARG_CONT'(ESPERA_MAX));

  // State, wait counter and sticky error
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado <= RESET;
      cont   <= '0;
      erro   <= 1'b0;
    end else begin
      estado <= estado_prox;
      erro   <= erro | set_erro;
      if (estado == BUSCA1 || estado == OPER) begin
        if (!mem_pronto) cont <= cont + LARG_CONT'(1);
      end else begin
        cont <= '0;
      end
    end
  end

  always_comb begin
    estado_prox = estado;
    sel_ula     = ULA_SOMA;
    carga_ac    = 1'b0;
    carga_nz    = 1'b0;
    carga_pc    = 1'b0;
    inc_pc      = 1'b0;
    carga_rem   = 1'b0;
    sel_rem     = 1'b0;
    carga_rdm   = 1'b0;
    carga_ri    = 1'b0;
    mem_le      = 1'b0;
    mem_escreve = 1'b0;
    parado      = 1'b0;
    set_erro    = 1'b0;
    case (estado)
      RESET: estado_prox = BUSCA0;
      BUSCA0: begin
        carga_rem   = 1'b1;
        estado_prox = BUSCA1;
      end
      BUSCA1: begin
        mem_le = 1'b1;
        if (mem_pronto) begin
          carga_rdm   = 1'b1;
          inc_pc      = 1'b1;
          estado_prox = BUSCA2;
        end else if (limite) begin
          set_erro    = 1'b1;
          estado_prox = PARADO;
        end
      end
      BUSCA2: begin
        carga_ri    = 1'b1;
        estado_prox = DECOD;
      end
      DECOD: begin
        estado_prox = BUSCA0;
        if (opcode == OP_HLT) begin
          estado_prox = PARADO;
        end else if (e_memoria) begin
          carga_rem   = 1'b1;
          sel_rem     = 1'b1;
          estado_prox = OPER;
        end else if (e_unaria) begin
          sel_ula  = dec_sel;
          carga_ac = 1'b1;
          carga_nz = 1'b1;
        end else if (e_salto) begin
          case (opcode)
            OP_JN:   carga_pc = flag_n;
            OP_JZ:   carga_pc = flag_z;
            default: carga_pc = 1'b1;
          endcase
        end
      end
      // Stores finish here; loads and ALU ops capture the operand for EXEC
      OPER: begin
        if (opcode == OP_STA) mem_escreve = 1'b1;
        else                  mem_le      = 1'b1;
        if (mem_pronto) begin
          if (opcode == OP_STA) begin
            estado_prox = BUSCA0;
          end else begin
            carga_rdm   = 1'b1;
            estado_prox = EXEC;
          end
        end else if (limite) begin
          set_erro    = 1'b1;
          estado_prox = PARADO;
        end
      end
      EXEC: begin
        sel_ula     = dec_sel;
        carga_ac    = 1'b1;
        carga_nz    = 1'b1;
        estado_prox = BUSCA0;
      end
      PARADO: begin
        parado = 1'b1;
        if (continuar && !erro) estado_prox = BUSCA0;
      end
      default: estado_prox = RESET;
    endcase
  end

endmodule

// File: tb/tb_unidade_controle.sv
// Directed bench for unidade_controle with a small datapath/memory model around it.
module tb_unidade_controle;

  logic        clock;
  logic        reset_n;
  logic [3:0]  opcode;
  logic        flag_n, flag_z, continuar;
  logic        mem_pronto = 1'b0;
  logic [2:0]  sel_ula;
  logic        carga_ac, carga_nz, carga_pc, inc_pc, carga_rem, sel_rem;
  logic        carga_rdm, carga_ri, mem_le, mem_escreve, parado, erro;
  logic [14:0] saidas;

  unidade_controle #(.ESPERA_MAX(4), .LARG_CONT(16)) dut (
    .clock(clock), .reset_n(reset_n), .opcode(opcode), .flag_n(flag_n),
    .flag_z(flag_z), .mem_pronto(mem_pronto), .continuar(continuar),
    .sel_ula(sel_ula), .carga_ac(carga_ac), .carga_nz(carga_nz),
    .carga_pc(carga_pc), .inc_pc(inc_pc), .carga_rem(carga_rem),
    .sel_rem(sel_rem), .carga_rdm(carga_rdm), .carga_ri(carga_ri),
    .mem_le(mem_le), .mem_escreve(mem_escreve), .parado(parado), .erro(erro)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  assign saidas = {sel_ula, carga_ac, carga_nz, carga_pc, inc_pc, carga_rem, sel_rem,
                   carga_rdm, carga_ri, mem_le, mem_escreve, parado, erro};

  // Datapath and memory model
  logic [15:0] mem [0:4095];
  logic [11:0] pc, rem_r, wr_addr;
  logic [15:0] rdm, ri, ac, wr_data;
  int          wr_cnt, espera, atraso;
  logic        travado;

  assign opcode = ri[15:12];

  function automatic logic [15:0] alu(input logic [2:0] s, input logic [15:0] a,
                                      input logic [15:0] y);
    case (s)
      3'd0:    return a + y;
      3'd1:    return a - y;
      3'd2:    return a & y;
      3'd3:    return a | y;
      3'd4:    return ~a;
      3'd5:    return a >> 1;
      3'd6:    return a << 1;
      default: return y;
    endcase
  endfunction

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc <= '0; rem_r <= '0; rdm <= '0; ri <= '0; ac <= '0;
      wr_addr <= '0; wr_data <= '0; wr_cnt <= 0; espera <= 0;
    end else begin
      if (carga_rem) rem_r <= sel_rem ? ri[11:0] : pc;
      if (carga_rdm) rdm <= mem[rem_r];
      if (inc_pc)    pc <= pc + 12'd1;
      if (carga_pc)  pc <= ri[11:0];
      if (carga_ri)  ri <= rdm;
      if (carga_ac)  ac <= alu(sel_ula, ac, rdm);
      if (mem_escreve && mem_pronto) begin
        wr_addr <= rem_r; wr_data <= ac; wr_cnt <= wr_cnt + 1;
      end
      if ((mem_le || mem_escreve) && !mem_pronto) espera <= espera + 1;
      else espera <= 0;
    end
  end

  // Ready answers after 'atraso' waiting cycles, updated mid-cycle
  always @(negedge clock)
    mem_pronto <= !travado && (mem_le || mem_escreve) && (espera >= atraso);

  int n_vec = 0;
  int n_err = 0;

  task automatic verifica(input string nome, input logic [15:0] atual,
                          input logic [15:0] esperado);
    n_vec++;
    if (atual !== esperado) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nome, atual, esperado);
    end
  endtask

  task automatic ciclo();
    @(negedge clock);
    #1;
  endtask

  task automatic limpa();
    for (int k = 0; k < 4096; k++) mem[k] = 16'h0000;
  endtask

  // Holds reset two cycles and returns just after release (state RESET)
  task automatic reinicia();
    reset_n = 1'b0; continuar = 1'b0; travado = 1'b0; atraso = 0;
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    #1;
  endtask

  task automatic salto(input logic [3:0] op, input logic fn, input logic fz,
                       input logic [11:0] exp_rem, input string nome);
    limpa();
    mem[0] = {op, 12'h020};
    flag_n = fn; flag_z = fz;
    reinicia();
    repeat (6) ciclo();
    verifica(nome, 16'(rem_r), 16'(exp_rem));
  endtask

  typedef struct {
    logic [3:0]  op;
    logic        fn;
    logic        fz;
    logic [15:0] exp_dec;
    logic [15:0] exp_prox;
  } vec_t;

  vec_t        tab [17];
  logic [15:0] traco [1:22];
  logic [15:0] esp_atraso [5:10];

  initial begin
    reset_n = 1'b0; flag_n = 1'b0; flag_z = 1'b0; continuar = 1'b0;
    travado = 1'b0; atraso = 0;
    tab[0]  = '{4'h0, 1'b0, 1'b0, 16'h0000, 16'h0080};
    tab[1]  = '{4'h1, 1'b0, 1'b0, 16'h00C0, 16'h0004};
    tab[2]  = '{4'h2, 1'b0, 1'b0, 16'h00C0, 16'h0028};
    tab[3]  = '{4'h3, 1'b0, 1'b0, 16'h00C0, 16'h0028};
    tab[4]  = '{4'h4, 1'b0, 1'b0, 16'h00C0, 16'h0028};
    tab[5]  = '{4'h5, 1'b0, 1'b0, 16'h00C0, 16'h0028};
    tab[6]  = '{4'h6, 1'b0, 1'b0, 16'h00C0, 16'h0028};
    tab[7]  = '{4'h7, 1'b0, 1'b0, 16'h4C00, 16'h0080};
    tab[8]  = '{4'h8, 1'b0, 1'b0, 16'h5C00, 16'h0080};
    tab[9]  = '{4'h9, 1'b0, 1'b0, 16'h6C00, 16'h0080};
    tab[10] = '{4'hA, 1'b0, 1'b0, 16'h0200, 16'h0080};
    tab[11] = '{4'hB, 1'b1, 1'b0, 16'h0200, 16'h0080};
    tab[12] = '{4'hB, 1'b0, 1'b1, 16'h0000, 16'h0080};
    tab[13] = '{4'hC, 1'b0, 1'b1, 16'h0200, 16'h0080};
    tab[14] = '{4'hC, 1'b1, 1'b0, 16'h0000, 16'h0080};
    tab[15] = '{4'hD, 1'b1, 1'b1, 16'h0000, 16'h0080};
    tab[16] = '{4'hF, 1'b0, 1'b0, 16'h0000, 16'h0002};

    // Decode outputs and the following state, one instruction at address 0
    for (int i = 0; i < 17; i++) begin
      limpa();
      mem[0]  = {tab[i].op, 12'h010};
      mem[16] = 16'h0003;
      flag_n  = tab[i].fn;
      flag_z  = tab[i].fz;
      reinicia();
      repeat (4) ciclo();
      verifica($sformatf("decod_%0d_op%h", i, tab[i].op), 16'(saidas), tab[i].exp_dec);
      ciclo();
      verifica($sformatf("prox_%0d_op%h", i, tab[i].op), 16'(saidas), tab[i].exp_prox);
    end
    flag_n = 1'b0; flag_z = 1'b0;

    // Reset asserted mid-fetch clears outputs immediately
    limpa();
    reinicia();
    ciclo(); ciclo();
    verifica("busca1_antes_reset", 16'(saidas), 16'h0128);
    #2 reset_n = 1'b0;
    #1 verifica("reset_assincrono", 16'(saidas), 16'h0000);
    @(negedge clock);
    reset_n = 1'b1;
    #1 verifica("estado_reset", 16'(saidas), 16'h0000);
    ciclo();
    verifica("busca0_pos_reset", 16'(saidas), 16'h0080);

    // LDA 0x010, ADD 0x011, STA 0x012, HLT
    limpa();
    mem[0] = 16'h2010; mem[1] = 16'h3011; mem[2] = 16'h1012; mem[3] = 16'hF000;
    mem[16'h10] = 16'd7; mem[16'h11] = 16'd5;
    reinicia();
    for (int c = 1; c <= 22; c++) begin
      ciclo();
      traco[c] = 16'(saidas);
    end
    verifica("prog_exec_lda", traco[6], 16'h7C00);
    verifica("prog_exec_add", traco[12], 16'h0C00);
    verifica("prog_oper_sta", traco[17], 16'h0004);
    verifica("prog_decod_hlt", traco[21], 16'h0000);
    verifica("prog_parado_22", traco[22], 16'h0002);
    verifica("prog_wr_cnt", 16'(wr_cnt), 16'd1);
    verifica("prog_wr_addr", 16'(wr_addr), 16'h0012);
    verifica("prog_wr_data", wr_data, 16'd12);

    // Conditional jumps: taken loads RI[11:0], not taken fetches PC+1
    salto(4'hC, 1'b0, 1'b1, 12'h020, "jz_tomado");
    salto(4'hC, 1'b1, 1'b0, 12'h001, "jz_nao_tomado");
    salto(4'hB, 1'b1, 1'b0, 12'h020, "jn_tomado");
    salto(4'hB, 1'b0, 1'b1, 12'h001, "jn_nao_tomado");

    // LDA with the operand read delayed 3 cycles
    limpa();
    mem[0] = 16'h2010; mem[16'h10] = 16'd7;
    esp_atraso[5] = 16'h0008; esp_atraso[6] = 16'h0008; esp_atraso[7] = 16'h0008;
    esp_atraso[8] = 16'h0028; esp_atraso[9] = 16'h7C00; esp_atraso[10] = 16'h0080;
    reinicia();
    repeat (4) ciclo();
    atraso = 3;
    for (int c = 5; c <= 10; c++) begin
      ciclo();
      verifica($sformatf("atraso_ciclo%0d", c), 16'(saidas), esp_atraso[c]);
    end
    atraso = 0;
    verifica("atraso_ac", ac, 16'd7);

    // Memory never ready during fetch: timeout after ESPERA_MAX
    limpa();
    reinicia();
    travado = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      ciclo();
      verifica($sformatf("timeout_ciclo%0d", c), 16'(saidas),
               (c == 1) ? 16'h0080 : (c == 7) ? 16'h0003 : 16'h0008);
    end
    continuar = 1'b1;
    ciclo();
    verifica("timeout_continuar1", 16'(saidas), 16'h0003);
    ciclo();
    verifica("timeout_continuar2", 16'(saidas), 16'h0003);
    continuar = 1'b0;
    reset_n = 1'b0;
    #1 verifica("timeout_reset_limpa", 16'(saidas), 16'h0000);
    travado = 1'b0;

    // NOT, HLT, then restart with continuar
    limpa();
    mem[0] = 16'h7000; mem[1] = 16'hF000;
    reinicia();
    repeat (4) ciclo();
    verifica("not_decod", 16'(saidas), 16'h4C00);
    repeat (5) ciclo();
    verifica("hlt_parado", 16'(saidas), 16'h0002);
    continuar = 1'b1;
    ciclo();
    verifica("continuar_busca0", 16'(saidas), 16'h0080);
    continuar = 1'b0;
    verifica("not_ac", ac, 16'hFFFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/unidade_controle.md
Name: unidade_controle

Overview:
- Multi-cycle control unit for the 16-bit accumulator processor. It drives the ALU `select` code and the datapath load strobes, and consumes the registered ALU flags N and Z.
- It is the sequencing counterpart of the ALU. It runs fetch → decode → operand read → execute/write-back against a single-port memory with a ready handshake.
- It sits between the instruction register (RI), the memory interface and the datapath registers PC, REM, RDM, AC and NZ.

Parameters:
- ESPERA_MAX, 255: maximum cycles to wait for `mem_pronto` before declaring a bus error. Range 1..65535.
- LARG_CONT, 16: width of the wait counter. Must satisfy 2^LARG_CONT > ESPERA_MAX.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- opcode  in  4  RI[15:12], valid from the cycle after `carga_ri`.
- flag_n  in  1  registered N flag from the NZ register.
- flag_z  in  1  registered Z flag from the NZ register.
- mem_pronto  in  1  memory ready: read data valid, or write accepted.
- continuar  in  1  restart pulse while halted.
- sel_ula  out  3  ALU operation code.
- carga_ac  out  1  load AC with the ALU result.
- carga_nz  out  1  load the NZ flag register.
- carga_pc  out  1  load PC with RI[11:0].
- inc_pc  out  1  PC <= PC+1.
- carga_rem  out  1  load the memory address register.
- sel_rem  out  1  REM source: 0 = PC, 1 = RI[11:0].
- carga_rdm  out  1  load RDM from memory data.
- carga_ri  out  1  load RI from RDM.
- mem_le  out  1  memory read request.
- mem_escreve  out  1  memory write request (data = AC).
- parado  out  1  high in the PARADO state.
- erro  out  1  sticky bus-timeout flag, cleared only by reset.

Behaviour:
- All outputs are decoded combinationally from the state register and inputs.
  - The state register and wait counter are the only flops, plus `erro`.
  - While reset_n=0: state=RESET, counter=0, erro=0, and every output is 0, immediately and asynchronously.
- Opcodes:
  - 0 NOP, 1 STA, 2 LDA, 3 ADD, 4 SUB, 5 AND, 6 OR, 7 NOT, 8 SHR, 9 SHL, A JMP, B JN, C JZ, F HLT.
  - D and E execute as NOP.
- sel_ula mapping: ADD 000, SUB 001, AND 010, OR 011, NOT 100, SHR 101, SHL 110, LDA 111 (pass Y = RDM). Outside execute states, sel_ula=000.
- State transitions:
  - RESET: outputs idle → BUSCA0.
  - BUSCA0: carga_rem=1, sel_rem=0 → BUSCA1.
  - BUSCA1: mem_le=1 held. When mem_pronto: carga_rdm=1, inc_pc=1 → BUSCA2.
  - BUSCA2: carga_ri=1 → DECOD.
  - DECOD:
    - NOP/D/E → BUSCA0.
    - NOT/SHR/SHL: sel_ula=op, carga_ac=1, carga_nz=1 → BUSCA0.
    - JMP: carga_pc=1 → BUSCA0.
    - JN: carga_pc=flag_n → BUSCA0.
    - JZ: carga_pc=flag_z → BUSCA0.
    - HLT → PARADO.
    - STA/LDA/ADD/SUB/AND/OR: carga_rem=1, sel_rem=1 → OPER.
  - OPER:
    - STA: mem_escreve=1 held until mem_pronto → BUSCA0.
    - Others: mem_le=1 held. On mem_pronto: carga_rdm=1 → EXEC.
  - EXEC: sel_ula=op, carga_ac=1, carga_nz=1 → BUSCA0. STA never writes flags.
  - PARADO: parado=1, all strobes 0. `continuar`=1 → BUSCA0, unless erro=1, in which case it stays.
- Memory handshake:
  - mem_le and mem_escreve never assert together and stay stable until the cycle mem_pronto=1 is sampled; they drop the next cycle.
  - mem_pronto outside BUSCA1/OPER is ignored.
- Wait counter:
  - Cleared on entry to BUSCA1/OPER; increments each cycle mem_pronto=0.
  - When it reaches ESPERA_MAX without ready: erro<=1 → PARADO, with no load strobe that cycle.
  - mem_pronto on the same cycle as the limit counts as success.
- inc_pc and carga_pc are never asserted together. Exact instruction latencies (mem_pronto in the first requesting cycle):
  - ALU-immediate (NOT/SHR/SHL) and jumps: 4 cycles.
  - STA: 5 cycles.
  - Memory ALU ops (LDA/ADD/SUB/AND/OR): 6 cycles.
- Unknown/X opcode is treated as NOP (default branch).

Decomposition:
- Shared package `proc_pkg`:
  - opcode constants (OP_NOP..OP_HLT);
  - ALU select constants (ULA_SOMA, ULA_SUB, ULA_AND, ULA_OR, ULA_NOT, ULA_SHR, ULA_SHL, ULA_PASSA_Y), also used by the ALU;
  - state encoding enum.
- One natural sub-module: `decod_ula`, a combinational opcode → {sel_ula, e_memoria, e_salto, e_unaria} decoder.

Test Plan:
- Reset mid-fetch (assert reset_n=0 during BUSCA1 with mem_le=1) → all outputs 0 the same cycle. After release: RESET, then BUSCA0 with carga_rem=1, sel_rem=0.
- Program LDA 0x010, ADD 0x011, STA 0x012, HLT; mem[0x10]=7, mem[0x11]=5; mem_pronto always 1 → sel_ula 111 then 000 in EXEC; write of 12 at 0x012; parado=1 after 6+6+5+4 = 21 cycles.
- JZ with flag_z=1 → carga_pc=1 in DECOD. JZ with flag_z=0 → carga_pc=0, next fetch from PC+1. Same pair for JN/flag_n.
- LDA with mem_pronto delayed 3 cycles → mem_le held 4 cycles, carga_rdm only in the 4th, total 9 cycles.
- ESPERA_MAX=4, mem_pronto stuck 0 in BUSCA1 → erro=1, parado=1, no carga_rdm; `continuar` ignored until reset.
- NOT then HLT, then continuar pulse → sel_ula=100 with carga_nz=1 in DECOD; leaves PARADO the next cycle into BUSCA0.
